// File: rtl/hp_manager.sv
// hp_manager: bomb blast damage, per-player HP targets and per-frame HP drain
// for the two-player bomb game; drives the scoreboard HP bars and end-of-round flags.
module hp_manager #(
  parameter int HP_MAX     = 200,
  parameter int BLAST_R    = 48,
  parameter int DRAIN_STEP = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_clk,
  input  logic       boom1,
  input  logic       boom2,
  input  logic [9:0] B1X,
  input  logic [9:0] B1Y,
  input  logic [9:0] B2X,
  input  logic [9:0] B2Y,
  input  logic [9:0] P1X,
  input  logic [9:0] P1Y,
  input  logic [9:0] P2X,
  input  logic [9:0] P2Y,
  output logic [9:0] HP1,
  output logic [9:0] HPP1,
  output logic [9:0] HP2,
  output logic [9:0] HPP2,
  output logic       busy,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [9:0] HP_FULL = 10'(HP_MAX);
  localparam logic [9:0] RADIUS  = 10'(BLAST_R);
  localparam logic [9:0] STEP    = 10'(DRAIN_STEP);

  typedef enum logic [2:0] {IDLE, LATCH, DIST, DMG, APPLY} state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] rst_pipe;
  logic       rst_n;
  logic [2:0] frame_sync;
  logic [2:0] boom1_sync;
  logic [2:0] boom2_sync;
  logic       frame_edge;
  logic       boom1_edge;
  logic       boom2_edge;
  logic       pend1;
  logic       pend2;
  logic       take1;
  logic       take2;
  logic [9:0] bomb_x;
  logic [9:0] bomb_y;
  logic [9:0] dist1;
  logic [9:0] dist2;
  logic [9:0] dmg1;
  logic [9:0] dmg2;
  logic [9:0] tgt1;
  logic [9:0] tgt2;
  logic [9:0] hp1_next;
  logic [9:0] hp2_next;
  logic       hp1_zero;
  logic       hp2_zero;

  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [9:0] cheb(input logic [9:0] dx, input logic [9:0] dy);
    return (dx > dy) ? dx : dy;
  endfunction

  function automatic logic [9:0] blast(input logic [9:0] d);
    return (d < RADIUS) ? (RADIUS - d) : 10'd0;
  endfunction

  function automatic logic [9:0] drained(input logic [9:0] hp, input logic [9:0] tgt);
    if (hp <= tgt) return hp;
    else if ((hp - tgt) > STEP) return hp - STEP;
    else return tgt;
  endfunction

  // Reset asserts asynchronously but is only released on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_pipe <= 2'b00;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_n = rst_pipe[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_sync <= 3'b000;
      boom1_sync <= 3'b000;
      boom2_sync <= 3'b000;
    end else begin
      frame_sync <= {frame_sync[1:0], frame_clk};
      boom1_sync <= {boom1_sync[1:0], boom1};
      boom2_sync <= {boom2_sync[1:0], boom2};
    end
  end

  assign frame_edge = frame_sync[1] & ~frame_sync[2];
  assign boom1_edge = boom1_sync[1] & ~boom1_sync[2];
  assign boom2_edge = boom2_sync[1] & ~boom2_sync[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    take1      = 1'b0;
    take2      = 1'b0;
    case (state)
      IDLE: begin
        if ((pend1 || pend2) && !game_over) begin
          state_next = LATCH;
          take1      = pend1;
          take2      = !pend1;
        end
      end
      LATCH:   state_next = DIST;
      DIST:    state_next = DMG;
      DMG:     state_next = APPLY;
      APPLY:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // An edge arriving while its flag is already set is dropped, not queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend1 <= 1'b0;
      pend2 <= 1'b0;
    end else if (game_over) begin
      pend1 <= 1'b0;
      pend2 <= 1'b0;
    end else begin
      if (take1)           pend1 <= 1'b0;
      else if (boom1_edge) pend1 <= 1'b1;
      if (take2)           pend2 <= 1'b0;
      else if (boom2_edge) pend2 <= 1'b1;
    end
  end

  // Each stage's register work lands on the edge that enters its state, so the
  // targets move on the 4th edge after the pend flag was set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bomb_x <= '0;
      bomb_y <= '0;
      dist1  <= '0;
      dist2  <= '0;
      dmg1   <= '0;
      dmg2   <= '0;
      tgt1   <= HP_FULL;
      tgt2   <= HP_FULL;
    end else begin
      if (take1) begin
        bomb_x <= B1X;
        bomb_y <= B1Y;
      end else if (take2) begin
        bomb_x <= B2X;
        bomb_y <= B2Y;
      end
      if (state == LATCH) begin
        dist1 <= cheb(abs_diff(P1X, bomb_x), abs_diff(P1Y, bomb_y));
        dist2 <= cheb(abs_diff(P2X, bomb_x), abs_diff(P2Y, bomb_y));
      end
      if (state == DIST) begin
        dmg1 <= blast(dist1);
        dmg2 <= blast(dist2);
      end
      if (state == DMG && !game_over) begin
        tgt1 <= (tgt1 > dmg1) ? (tgt1 - dmg1) : 10'd0;
        tgt2 <= (tgt2 > dmg2) ? (tgt2 - dmg2) : 10'd0;
      end
    end
  end

  always_comb begin
    hp1_next = HP1;
    hp2_next = HP2;
    if (frame_edge) begin
      hp1_next = drained(HP1, tgt1);
      hp2_next = drained(HP2, tgt2);
    end
  end

  assign hp1_zero = (hp1_next == 10'd0);
  assign hp2_zero = (hp2_next == 10'd0);

  // Padding is registered from the same next value so the bar always sums to HP_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      HP1       <= HP_FULL;
      HP2       <= HP_FULL;
      HPP1      <= '0;
      HPP2      <= '0;
      game_over <= 1'b0;
      winner    <= 2'b00;
    end else begin
      HP1  <= hp1_next;
      HP2  <= hp2_next;
      HPP1 <= HP_FULL - hp1_next;
      HPP2 <= HP_FULL - hp2_next;
      if (!game_over && (hp1_zero || hp2_zero)) begin
        game_over <= 1'b1;
        winner    <= {hp1_zero, hp2_zero};
      end
    end
  end

endmodule

// File: tb/tb_hp_manager.sv
// tb_hp_manager: directed scenarios for hp_manager checked every cycle against an
// event-level model of damage, drain and end-of-round rules, plus literal checkpoints.
module tb_hp_manager;

  localparam int HPM   = 200;
  localparam int RAD   = 48;
  localparam int DRAIN = 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic       boom1 = 1'b0;
  logic       boom2 = 1'b0;
  logic [9:0] B1X = '0, B1Y = '0, B2X = '0, B2Y = '0;
  logic [9:0] P1X = '0, P1Y = '0, P2X = '0, P2Y = '0;
  logic [9:0] HP1, HPP1, HP2, HPP2;
  logic       busy, game_over;
  logic [1:0] winner;

  int n_cmp = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  int cyc = 0;
  int frame_q[$];
  int b1_q[$];
  int b2_q[$];
  int m_hp1 = HPM, m_hp2 = HPM, m_t1 = HPM, m_t2 = HPM;
  int m_left = 0, m_dmg1 = 0, m_dmg2 = 0;
  bit m_pend1 = 1'b0, m_pend2 = 1'b0, m_go = 1'b0;
  bit [1:0] m_win = 2'b00;

  hp_manager dut (
    .clk(clk), .reset_n(reset_n), .frame_clk(frame_clk),
    .boom1(boom1), .boom2(boom2),
    .B1X(B1X), .B1Y(B1Y), .B2X(B2X), .B2Y(B2Y),
    .P1X(P1X), .P1Y(P1Y), .P2X(P2X), .P2Y(P2Y),
    .HP1(HP1), .HPP1(HPP1), .HP2(HP2), .HPP2(HPP2),
    .busy(busy), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  function automatic int blast_dmg(int bx, int by, int px, int py);
    int dx = (bx > px) ? bx - px : px - bx;
    int dy = (by > py) ? by - py : py - by;
    int d  = (dx > dy) ? dx : dy;
    return (d < RAD) ? RAD - d : 0;
  endfunction

  function automatic int drain_to(int hp, int t);
    if (hp > t) return hp - (((hp - t) < DRAIN) ? (hp - t) : DRAIN);
    return hp;
  endfunction

  // Events act 3 edges after the bench raises an input; a started explosion
  // occupies the processor for 4 cycles and moves the targets on its 3rd edge.
  always @(posedge clk or negedge reset_n) begin : model
    bit f, e1, e2, old_go, took1, took2;
    if (!reset_n) begin
      m_hp1 = HPM; m_hp2 = HPM; m_t1 = HPM; m_t2 = HPM;
      m_left = 0; m_dmg1 = 0; m_dmg2 = 0;
      m_pend1 = 1'b0; m_pend2 = 1'b0; m_go = 1'b0; m_win = 2'b00;
      frame_q.delete(); b1_q.delete(); b2_q.delete();
    end else begin
      cyc++;
      f = 1'b0; e1 = 1'b0; e2 = 1'b0; took1 = 1'b0; took2 = 1'b0;
      if (frame_q.size() > 0 && frame_q[0] == cyc) begin f = 1'b1; void'(frame_q.pop_front()); end
      if (b1_q.size() > 0 && b1_q[0] == cyc) begin e1 = 1'b1; void'(b1_q.pop_front()); end
      if (b2_q.size() > 0 && b2_q[0] == cyc) begin e2 = 1'b1; void'(b2_q.pop_front()); end
      old_go = m_go;
      if (f) begin
        m_hp1 = drain_to(m_hp1, m_t1);
        m_hp2 = drain_to(m_hp2, m_t2);
      end
      if (m_left == 2 && !old_go) begin
        m_t1 = (m_t1 > m_dmg1) ? m_t1 - m_dmg1 : 0;
        m_t2 = (m_t2 > m_dmg2) ? m_t2 - m_dmg2 : 0;
      end
      if (m_left > 0) m_left--;
      else if (!old_go && (m_pend1 || m_pend2)) begin
        if (m_pend1) begin
          m_dmg1 = blast_dmg(B1X, B1Y, P1X, P1Y);
          m_dmg2 = blast_dmg(B1X, B1Y, P2X, P2Y);
          took1 = 1'b1;
        end else begin
          m_dmg1 = blast_dmg(B2X, B2Y, P1X, P1Y);
          m_dmg2 = blast_dmg(B2X, B2Y, P2X, P2Y);
          took2 = 1'b1;
        end
        m_left = 4;
      end
      if (old_go) begin
        m_pend1 = 1'b0; m_pend2 = 1'b0;
      end else begin
        if (took1) m_pend1 = 1'b0; else if (e1) m_pend1 = 1'b1;
        if (took2) m_pend2 = 1'b0; else if (e2) m_pend2 = 1'b1;
      end
      if (!m_go && (m_hp1 == 0 || m_hp2 == 0)) begin
        m_go  = 1'b1;
        m_win = {m_hp1 == 0, m_hp2 == 0};
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      n_cmp++;
      if (int'(HP1) != m_hp1 || int'(HP2) != m_hp2 ||
          int'(HPP1) != HPM - m_hp1 || int'(HPP2) != HPM - m_hp2 ||
          busy != (m_left > 0) || game_over != m_go || winner != m_win) begin
        n_fail++;
        $display("[TB] FAIL model cyc=%0d got HP1=%0d HP2=%0d HPP1=%0d HPP2=%0d busy=%0d go=%0d win=%0d expected HP1=%0d HP2=%0d HPP1=%0d HPP2=%0d busy=%0d go=%0d win=%0d",
                 cyc, HP1, HP2, HPP1, HPP2, busy, game_over, winner,
                 m_hp1, m_hp2, HPM - m_hp1, HPM - m_hp2, (m_left > 0), m_go, m_win);
      end
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      frame_clk = 1'b1;
      frame_q.push_back(cyc + 3);
      repeat (3) @(posedge clk);
      #1 frame_clk = 1'b0;
      repeat (3) @(posedge clk);
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_stimulus(input bit f1, input bit f2);
    @(posedge clk); #1;
    if (f1) begin boom1 = 1'b1; b1_q.push_back(cyc + 3); end
    if (f2) begin boom2 = 1'b1; b2_q.push_back(cyc + 3); end
    repeat (3) @(posedge clk);
    #1;
    boom1 = 1'b0;
    boom2 = 1'b0;
  endtask

  task automatic count_busy(input int n, output int cnt, output int span);
    int first = -1;
    int last = -1;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
    end
    span = (first < 0) ? 0 : last - first + 1;
  endtask

  initial begin
    #1000000;
    n_fail++;
    $display("[TB] FAIL watchdog: run did not complete within the time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt, span;
    bit seen;
    repeat (2) @(posedge clk);
    check_en = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    wait_cycles(6);

    frames(5);
    check_output("idle_hp1", int'(HP1), 200);
    check_output("idle_hp2", int'(HP2), 200);
    check_output("idle_hpp1", int'(HPP1), 0);
    check_output("idle_hpp2", int'(HPP2), 0);
    check_output("idle_busy", int'(busy), 0);
    check_output("idle_winner", int'(winner), 0);

    P1X = 110; P1Y = 130; P2X = 400; P2Y = 100; B1X = 100; B1Y = 100;
    apply_stimulus(1'b1, 1'b0);
    count_busy(12, cnt, span);
    check_output("single_busy_cycles", cnt, 4);
    frames(18);
    check_output("single_hp1_18f", int'(HP1), 182);
    check_output("single_hpp1_18f", int'(HPP1), 18);
    check_output("single_hp2_18f", int'(HP2), 200);
    frames(2);
    check_output("single_hp1_20f", int'(HP1), 182);

    B1X = 300; B1Y = 300; B2X = 300; B2Y = 300; P2X = 300; P2Y = 300;
    apply_stimulus(1'b1, 1'b1);
    count_busy(14, cnt, span);
    check_output("dual_busy_cycles", cnt, 8);
    check_output("dual_busy_span", span, 9);
    frames(96);
    check_output("dual_hp2", int'(HP2), 104);
    check_output("dual_hpp2", int'(HPP2), 96);
    check_output("dual_hp1", int'(HP1), 182);

    P1X = 5; P1Y = 100; B1X = 20; B1Y = 148;
    apply_stimulus(1'b1, 1'b0);
    wait_cycles(10);
    B1Y = 147;
    apply_stimulus(1'b1, 1'b0);
    wait_cycles(10);
    frames(2);
    check_output("edge_r48_r47_hp1", int'(HP1), 181);
    check_output("edge_r48_r47_hpp1", int'(HPP1), 19);
    B1Y = 100;
    apply_stimulus(1'b1, 1'b0);
    wait_cycles(10);
    frames(33);
    check_output("absdx_hp1", int'(HP1), 148);
    check_output("absdx_hpp1", int'(HPP1), 52);
    check_output("absdx_hp2", int'(HP2), 104);

    B1X = 5; B1Y = 100;
    apply_stimulus(1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check_output("abort_busy_seen", int'(seen), 1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check_output("abort_hp1", int'(HP1), 200);
    check_output("abort_hp2", int'(HP2), 200);
    check_output("abort_hpp1", int'(HPP1), 0);
    check_output("abort_hpp2", int'(HPP2), 0);
    check_output("abort_busy", int'(busy), 0);
    check_output("abort_go", int'(game_over), 0);
    check_output("abort_winner", int'(winner), 0);
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(6);
    frames(3);
    check_output("after_abort_hp1", int'(HP1), 200);
    check_output("after_abort_hp2", int'(HP2), 200);
    check_output("after_abort_busy", int'(busy), 0);

    P1X = 5; P1Y = 100; P2X = 300; P2Y = 300; B2X = 300; B2Y = 300;
    repeat (3) begin
      apply_stimulus(1'b0, 1'b1);
      wait_cycles(10);
    end
    B2X = 302;
    apply_stimulus(1'b0, 1'b1);
    wait_cycles(10);
    B2X = 300;
    apply_stimulus(1'b0, 1'b1);
    wait_cycles(10);
    frames(199);
    check_output("sat_hp2_199f", int'(HP2), 1);
    check_output("sat_go_199f", int'(game_over), 0);
    frames(1);
    check_output("sat_hp2_200f", int'(HP2), 0);
    check_output("sat_hpp2_200f", int'(HPP2), 200);
    check_output("sat_go", int'(game_over), 1);
    check_output("sat_winner", int'(winner), 1);
    check_output("sat_hp1", int'(HP1), 200);
    B2X = 5; B2Y = 100;
    apply_stimulus(1'b0, 1'b1);
    count_busy(12, cnt, span);
    check_output("over_busy_cycles", cnt, 0);
    frames(3);
    check_output("over_hp1", int'(HP1), 200);
    check_output("over_go", int'(game_over), 1);
    check_output("over_winner", int'(winner), 1);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hp_manager.md
Name: hp_manager

Overview:
Damage and health stage downstream of the two player/bomb engines and upstream of the scoreboard. It detects each bomb explosion and computes blast damage to both players from the bomb and player positions. It keeps a per-player target HP and drains the displayed HP toward that target once per video frame. It drives HP1/HPP1/HP2/HPP2 for the scoreboard and raises game-over/winner flags.

Parameters:
HP_MAX, 200, starting HP per player; HP + HPP = HP_MAX at all times
BLAST_R, 48, blast radius in pixels; damage = BLAST_R - d for d < BLAST_R, else 0
DRAIN_STEP, 1, maximum displayed-HP decrement per frame

Ports:
clk  in  1  system clock (CLOCK_50)
reset_n  in  1  asynchronous active-low reset
frame_clk  in  1  VGA vsync, asynchronous to clk
boom1  in  1  bomb 1 exploded (level, asynchronous)
boom2  in  1  bomb 2 exploded (level, asynchronous)
B1X, B1Y, B2X, B2Y  in  10 each  bomb centre positions, unsigned
P1X, P1Y, P2X, P2Y  in  10 each  player centre positions, unsigned
HP1, HP2  out  10 each  displayed HP
HPP1, HPP2  out  10 each  HP bar padding = HP_MAX - HPx
busy  out  1  damage FSM not in IDLE
game_over  out  1  sticky end-of-round flag
winner  out  2  01 = P1 wins, 10 = P2 wins, 11 = draw, 00 = none

Behaviour:
- Reset (async assert, sync release): HP1 = HP2 = T1 = T2 = HP_MAX, HPP1 = HPP2 = 0, busy = 0, game_over = 0, winner = 00, pend1 = pend2 = 0, FSM = IDLE, all synchronisers cleared.
- frame_clk, boom1 and boom2 each pass through a 2-FF synchroniser, then a rising-edge detector. The edge pulse is valid on the 3rd posedge after the input is first sampled high.
- A boomN edge sets pendN. If pendN is already set, the new edge is dropped with no queueing.
- FSM states: IDLE, LATCH, DIST, DMG, APPLY, one cycle each except IDLE.
  - IDLE: if pend1 or pend2 and !game_over, go to LATCH. pend1 has priority when both are set.
  - LATCH: register the selected bomb X/Y, clear that pend flag, set the source id, go to DIST. Positions are captured here only; later changes are ignored.
  - DIST: compute |dx| and |dy| for both players as 10-bit unsigned absolute differences. Register the Chebyshev distance d = max(|dx|, |dy|). Go to DMG.
  - DMG: per player, dmg = (d < BLAST_R) ? BLAST_R - d : 0. Go to APPLY.
  - APPLY: T -= dmg, saturating at 0. Go to IDLE. Both players take damage from either bomb, including self-damage.
- Latency: Tx updates on the 4th posedge after the pend flag is set. Back-to-back explosions are processed serially: bomb 1 first, then bomb 2 from the next IDLE visit.
- busy = (state != IDLE).
- Drain: on each synchronised frame_clk edge, if HPx > Tx then HPx -= min(DRAIN_STEP, HPx - Tx). HP never rises above Tx and never goes below 0.
- HPPx is registered and always equals HP_MAX - HPx in the same cycle as HPx.
- A drain edge and an APPLY in the same cycle: the drain uses the pre-APPLY Tx, and the new Tx is used from the next frame.
- game_over sets on the cycle HP1 == 0 or HP2 == 0 is first reached. winner is latched in the same cycle: 01 if only HP2 == 0, 10 if only HP1 == 0, 11 if both.
- While game_over is set:
  - new boom edges are ignored and pend flags are cleared;
  - the FSM completes any in-flight sequence, but APPLY has no effect;
  - drain continues toward the existing targets.
- game_over is cleared only by reset.
- Reset asserted mid-sequence aborts immediately to the reset state. No partial damage is retained.

Test Plan:
- Reset release, 5 frame pulses, no booms -> HP1 = HP2 = 200, HPP1 = HPP2 = 0, busy = 0, winner = 00.
- B1 = (100,100), P1 = (110,130), P2 = (400,100), boom1 rises -> busy high for 4 cycles, T1 = 182, T2 = 200. After 18 frames HP1 = 182, HPP1 = 18; after 20 frames HP1 is still 182.
- boom1 and boom2 rise in the same cycle, both bombs at P2 = (300,300), P1 far away -> bomb 1 processed first then bomb 2. T2 = 200 - 48 - 48 = 104. busy is high for 8 cycles with exactly 1 IDLE cycle between the two sequences.
- Bomb at distance 48 from P1 -> dmg = 0. Distance 47 -> dmg = 1. Also set P1X = 5, B1X = 20 to check the absolute-difference path: |dx| = 15.
- T2 = 10 with a direct hit (d = 0) -> T2 saturates at 0. HP2 drains to 0 and game_over = 1, winner = 01. A later boom2 leaves HP1 unchanged and busy stays 0.
- Drive reset_n low while the FSM is in DIST -> all outputs return to their reset values asynchronously. After release, the dropped event is not applied.
